// File: rtl/oh2b_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oh2b_pkg : shared constants and one-hot helpers for oh2b_pipe        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package oh2b_pkg;

  localparam int OH_N        = 3;
  localparam int OH_MAX_N    = 8;
  localparam int OH_VEC_W    = 1 << OH_MAX_N;
  localparam int OH_IDX_W    = OH_MAX_N;
  localparam int ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

  // Narrower codes are zero-extended by the caller; extra zeros change neither result.
  function automatic logic [OH_IDX_W-1:0] oh_index(input logic [OH_VEC_W-1:0] vec);
    logic [OH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = OH_VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = OH_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic oh_legal(input logic [OH_VEC_W-1:0] vec);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < OH_VEC_W; i++) begin
      if (vec[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oh2b_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oh2b_core : combinational one-hot to binary decode with legality flag|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module oh2b_core
  import oh2b_pkg::*;
#(
  parameter int N = OH_N
) (
  input  logic [(1<<N)-1:0] i_positional,
  output logic [N-1:0]      o_binary,
  output logic              o_err
);

  logic [OH_VEC_W-1:0] w_vec;

  assign w_vec    = OH_VEC_W'(i_positional);
  assign o_binary = N'(oh_index(w_vec));
  assign o_err    = ~oh_legal(w_vec);

endmodule
`default_nettype wire

// File: rtl/oh2b_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oh2b_pipe : registered one-hot to binary decoder, valid/ready ports. |
// |             OH2B_ERR_CNT_EN adds a saturating illegal-code counter.  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module oh2b_pipe
  import oh2b_pkg::*;
#(
  parameter int N = OH_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(1<<N)-1:0]    positional,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         binary,
  output logic                 err
`ifdef OH2B_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic         r_out_valid;
  logic [N-1:0] r_binary;
  logic         r_err;
  logic [N-1:0] w_binary_nxt;
  logic         w_err_nxt;
  logic         w_accept;

  oh2b_core #(.N(N)) u_core (
    .i_positional (positional),
    .o_binary     (w_binary_nxt),
    .o_err        (w_err_nxt)
  );

  // Single-entry stage: a full register can still accept when it drains this cycle.
  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_binary    <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_binary    <= w_binary_nxt;
      r_err       <= w_err_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign binary    = r_binary;
  assign err       = r_err;

`ifdef OH2B_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err_nxt && (r_err_cnt != ERR_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  // No counter in this build; the err_cnt port is absent.
`endif

endmodule
`default_nettype wire

// File: tb/tb_oh2b_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_oh2b_pipe : scoreboard bench for oh2b_pipe (N=3, 80 ns clock)     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_oh2b_pipe;

  typedef struct packed {
    logic [2:0] bin;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] positional;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] binary;
  logic       err;
`ifdef OH2B_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int   n_checks;
  int   n_errors;
  exp_t q[$];

  oh2b_pipe #(.N(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .positional (positional),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .binary     (binary),
    .err        (err)
`ifdef OH2B_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #40 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Independent reference: scan upward for the first set bit and count bits.
  function automatic exp_t model(input logic [7:0] p);
    exp_t r;
    int   cnt;
    logic found;
    r     = '0;
    cnt   = 0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) begin
        cnt++;
        if (!found) begin
          r.bin = 3'(i);
          found = 1'b1;
        end
      end
    end
    r.e = (cnt != 1);
    return r;
  endfunction

  // Called just after a negedge: drive, check pre-edge state, step one clock.
  task automatic cycle(input logic v, input logic [7:0] p, input logic r);
    exp_t e;
    logic model_valid;
    in_valid   = v;
    positional = p;
    out_ready  = r;
    #1;
    model_valid = (q.size() != 0);
    check("out_valid", 32'(out_valid), 32'(model_valid));
    check("in_ready", 32'(in_ready), 32'(!model_valid || r));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("binary", 32'(binary), 32'(e.bin));
        check("err", 32'(err), 32'(e.e));
      end
    end
    if (in_valid && in_ready) q.push_back(model(p));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    positional = '0;
    out_ready  = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_binary", 32'(binary), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef OH2B_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    do_reset();

    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(1 << i), 1'b1);
    cycle(1'b1, 8'b00000000, 1'b1);
    cycle(1'b1, 8'b00101000, 1'b1);
    cycle(1'b1, 8'b10000001, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    cycle(1'b1, 8'b00010000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'b01000000, 1'b0);
      check("stall_binary", 32'(binary), 32'd4);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    cycle(1'b1, 8'b01000000, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    cycle(1'b1, 8'b00100000, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #10;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'b00000100, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

`ifdef OH2B_ERR_CNT_EN
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, 8'h00, 1'b1);
    check("err_cnt_100", 32'(err_cnt), 32'd100);
    for (int i = 0; i < 200; i++) cycle(1'b1, 8'b00000011, 1'b1);
    check("err_cnt_sat", 32'(err_cnt), 32'hFF);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(1 << i), 1'b1);
    check("err_cnt_legal", 32'(err_cnt), 32'hFF);
    cycle(1'b0, 8'h00, 1'b1);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
